// File: rtl/im_fetch_ctrl_if.sv
// Bus bundle between the fetch/loader controller and its environment
// (loader byte stream, instruction-memory port, decode-side fetch register).
//   master : controller view (drives ld_ready, busy_load, im_*, f_valid/f_instr/f_pc)
//   slave  : environment view (drives ld_*, im_rdata, redirect*, f_ready)
interface im_fetch_ctrl_if #(
    parameter int unsigned IMW = 4,
    parameter int unsigned IW  = 32
);
    logic           ld_start;
    logic [IMW:0]   ld_len;
    logic           ld_valid;
    logic [7:0]     ld_data;
    logic           ld_ready;
    logic           busy_load;
    logic [IMW-1:0] im_addr;
    logic           im_we;
    logic [IW-1:0]  im_wdata;
    logic [IW-1:0]  im_rdata;
    logic           redirect;
    logic [IMW-1:0] redirect_pc;
    logic           f_valid;
    logic [IW-1:0]  f_instr;
    logic [IMW-1:0] f_pc;
    logic           f_ready;

    modport master (
        input  ld_start, ld_len, ld_valid, ld_data, im_rdata,
               redirect, redirect_pc, f_ready,
        output ld_ready, busy_load, im_addr, im_we, im_wdata,
               f_valid, f_instr, f_pc
    );

    modport slave (
        output ld_start, ld_len, ld_valid, ld_data, im_rdata,
               redirect, redirect_pc, f_ready,
        input  ld_ready, busy_load, im_addr, im_we, im_wdata,
               f_valid, f_instr, f_pc
    );
endinterface

// File: rtl/im_fetch_ctrl.sv
// Instruction-fetch sequencer and program-loader arbiter for the instruction
// memory address port.
//   clk, rst_n : clock, asynchronous active-low reset
//   io_bus     : im_fetch_ctrl_if.master
//                loader   : ld_start, ld_len, ld_valid, ld_data -> ld_ready, busy_load
//                memory   : im_addr, im_we, im_wdata, im_rdata (combinational read)
//                fetch    : redirect, redirect_pc, f_ready -> f_valid, f_instr, f_pc
module im_fetch_ctrl #(
    parameter int unsigned   IMW = 4,
    parameter int unsigned   IW  = 32,
    parameter logic [IW-1:0] NOP = 32'h00000013
) (
    input  logic             clk,
    input  logic             rst_n,
    im_fetch_ctrl_if.master  io_bus
);
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t         r_state, w_state_nxt;
    logic [IMW-1:0] r_pc;
    logic [IMW-1:0] r_waddr;
    logic [IMW:0]   r_len;
    logic [1:0]     r_bcnt;
    logic [IW-1:0]  r_asm;
    logic           r_f_valid;
    logic [IW-1:0]  r_f_instr;
    logic [IMW-1:0] r_f_pc;

    logic           w_ld_ready;
    logic           w_byte_acc;
    logic           w_last;
    logic [IMW:0]   w_waddr_inc;
    logic [IMW-1:0] w_addr;
    logic           w_we;

    // A zero-length load accepts no bytes and just returns to RUN
    assign w_ld_ready  = (r_state == LOAD) && (r_len != '0);
    assign w_byte_acc  = w_ld_ready && io_bus.ld_valid;
    assign w_waddr_inc = (IMW+1)'(r_waddr) + (IMW+1)'(1);
    assign w_last      = (w_waddr_inc == r_len);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= RUN;
        else        r_state <= w_state_nxt;
    end

    // Next state, memory address mux and write strobe
    always_comb begin
        w_state_nxt = r_state;
        w_addr      = r_pc;
        w_we        = 1'b0;
        case (r_state)
            RUN: begin
                w_addr = r_pc;
            end
            LOAD: begin
                w_addr = r_waddr;
                if (r_len == '0)
                    w_state_nxt = RUN;
                else if (w_byte_acc && (r_bcnt == 2'd3))
                    w_state_nxt = WRITE;
            end
            WRITE: begin
                w_addr      = r_waddr;
                w_we        = 1'b1;
                w_state_nxt = w_last ? RUN : LOAD;
            end
            default: w_state_nxt = RUN;
        endcase
        // A new load pre-empts everything, including a pending word write
        if (io_bus.ld_start) begin
            w_state_nxt = LOAD;
            w_we        = 1'b0;
        end
    end

    // Fetch register, PC and loader datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc      <= '0;
            r_waddr   <= '0;
            r_len     <= '0;
            r_bcnt    <= '0;
            r_asm     <= '0;
            r_f_valid <= 1'b0;
            r_f_instr <= NOP;
            r_f_pc    <= '0;
        end else if (io_bus.ld_start) begin
            r_waddr   <= '0;
            r_bcnt    <= '0;
            r_len     <= io_bus.ld_len;
            r_f_valid <= 1'b0;
            r_f_instr <= NOP;
        end else begin
            case (r_state)
                RUN: begin
                    if (io_bus.redirect) begin
                        // Redirect squashes this cycle's fetch
                        r_f_valid <= 1'b0;
                        r_f_instr <= NOP;
                        r_pc      <= io_bus.redirect_pc;
                    end else if (!r_f_valid || io_bus.f_ready) begin
                        r_f_valid <= 1'b1;
                        r_f_instr <= io_bus.im_rdata;
                        r_f_pc    <= r_pc;
                        r_pc      <= r_pc + IMW'(1);
                    end
                end
                LOAD: begin
                    if (r_len == '0) begin
                        r_pc <= '0;
                    end else if (w_byte_acc) begin
                        // Little-endian assembly: byte n lands in lane n
                        r_asm[{r_bcnt, 3'b000} +: 8] <= io_bus.ld_data;
                        r_bcnt                       <= r_bcnt + 2'd1;
                    end
                end
                WRITE: begin
                    if (w_last) r_pc    <= '0;
                    else        r_waddr <= r_waddr + IMW'(1);
                end
                default: ;
            endcase
        end
    end

    assign io_bus.ld_ready  = w_ld_ready;
    assign io_bus.busy_load = (r_state != RUN);
    assign io_bus.im_addr   = w_addr;
    assign io_bus.im_we     = w_we;
    assign io_bus.im_wdata  = r_asm;
    assign io_bus.f_valid   = r_f_valid;
    assign io_bus.f_instr   = r_f_instr;
    assign io_bus.f_pc      = r_f_pc;
endmodule

// File: tb/tb_im_fetch_ctrl.sv
// Scoreboard bench for im_fetch_ctrl: stimulus pushes expected fetch
// transfers and memory writes; a negedge monitor pops and compares them.
module tb_im_fetch_ctrl;
    localparam int unsigned IMW = 4;
    localparam int unsigned IW  = 32;
    localparam logic [31:0] NOP = 32'h00000013;

    typedef struct packed {
        logic [31:0]    instr;
        logic [IMW-1:0] pc;
    } fexp_t;

    typedef struct packed {
        logic [IMW-1:0] addr;
        logic [31:0]    data;
    } wexp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic mem_init = 1'b1;
    logic [31:0] mem [16];

    int checks = 0;
    int errors = 0;
    fexp_t fq[$];
    wexp_t wq[$];

    im_fetch_ctrl_if #(.IMW(IMW), .IW(IW)) bus ();

    im_fetch_ctrl #(.IMW(IMW), .IW(IW), .NOP(NOP)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    // Instruction memory: combinational read, synchronous write
    assign bus.im_rdata = mem[bus.im_addr];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int k = 0; k < 16; k++) mem[k] <= 32'(k);
        end else if (bus.im_we) begin
            mem[bus.im_addr] <= bus.im_wdata;
        end
    end

    // Monitor: compare every accepted fetch and every memory write
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.f_valid && bus.f_ready) begin
                checks++;
                if (fq.size() == 0) begin
                    errors++;
                    $display("FAIL fetch_unexpected: got instr=%h pc=%0d, none expected",
                             bus.f_instr, bus.f_pc);
                end else begin
                    fexp_t e;
                    e = fq.pop_front();
                    if (bus.f_instr !== e.instr || bus.f_pc !== e.pc) begin
                        errors++;
                        $display("FAIL fetch: got instr=%h pc=%0d, expected instr=%h pc=%0d",
                                 bus.f_instr, bus.f_pc, e.instr, e.pc);
                    end
                end
            end
            if (bus.im_we) begin
                checks++;
                if (bus.ld_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL ld_ready_in_write: got %b expected 0", bus.ld_ready);
                end
                checks++;
                if (wq.size() == 0) begin
                    errors++;
                    $display("FAIL write_unexpected: got addr=%0d data=%h, none expected",
                             bus.im_addr, bus.im_wdata);
                end else begin
                    wexp_t w;
                    w = wq.pop_front();
                    if (bus.im_addr !== w.addr || bus.im_wdata !== w.data) begin
                        errors++;
                        $display("FAIL write: got addr=%0d data=%h, expected addr=%0d data=%h",
                                 bus.im_addr, bus.im_wdata, w.addr, w.data);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_f(input logic [31:0] instr, input int pc);
        fexp_t e;
        e.instr = instr;
        e.pc    = IMW'(pc);
        fq.push_back(e);
    endtask

    task automatic push_w(input int addr, input logic [31:0] data);
        wexp_t w;
        w.addr = IMW'(addr);
        w.data = data;
        wq.push_back(w);
    endtask

    // Run until both scoreboard queues empty; n = cycles taken
    task automatic drain(input string name, output int n);
        n = 0;
        while ((fq.size() != 0 || wq.size() != 0) && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got %0d fetch + %0d writes pending, expected 0",
                     name, fq.size(), wq.size());
        end
    endtask

    // Idle gap cycles, then hold a byte until the DUT accepts it
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        for (int g = 0; g < gap; g++) tick();
        bus.ld_valid = 1'b1;
        bus.ld_data  = b;
        n = 0;
        while (!bus.ld_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL ld_ready_timeout: got ld_ready=0 expected 1");
        end
        tick();
        bus.ld_valid = 1'b0;
    endtask

    task automatic wait_run(input string name);
        int n;
        n = 0;
        while (bus.busy_load && n < 50) begin
            tick();
            n++;
        end
        chk(name, 32'(bus.busy_load), 32'd0);
    endtask

    task automatic start_load(input int len);
        bus.ld_start = 1'b1;
        bus.ld_len   = (IMW+1)'(len);
        tick();
        bus.ld_start = 1'b0;
    endtask

    logic [7:0] prog [8];

    initial begin
        int n;
        prog[0] = 8'h13; prog[1] = 8'h00; prog[2] = 8'h00; prog[3] = 8'h00;
        prog[4] = 8'hB3; prog[5] = 8'h06; prog[6] = 8'h00; prog[7] = 8'h00;

        bus.ld_start    = 1'b0;
        bus.ld_len      = '0;
        bus.ld_valid    = 1'b0;
        bus.ld_data     = '0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.f_ready     = 1'b0;

        // Reset values
        tick();
        tick();
        mem_init = 1'b0;
        chk("rst_f_valid",   32'(bus.f_valid),   32'd0);
        chk("rst_f_instr",   bus.f_instr,        NOP);
        chk("rst_f_pc",      32'(bus.f_pc),      32'd0);
        chk("rst_im_we",     32'(bus.im_we),     32'd0);
        chk("rst_im_wdata",  bus.im_wdata,       32'd0);
        chk("rst_ld_ready",  32'(bus.ld_ready),  32'd0);
        chk("rst_busy_load", 32'(bus.busy_load), 32'd0);
        chk("rst_im_addr",   32'(bus.im_addr),   32'd0);

        // Free run 0..15 then wrap to 0
        for (int k = 0; k < 16; k++) push_f(32'(k), k);
        push_f(32'd0, 0);
        rst_n       = 1'b1;
        bus.f_ready = 1'b1;
        drain("freerun", n);
        bus.f_ready = 1'b0;
        chk("freerun_cycles", 32'(n), 32'd18);

        // Stall with instruction 5 on the output
        for (int k = 1; k < 5; k++) push_f(32'(k), k);
        bus.f_ready = 1'b1;
        drain("prestall", n);
        bus.f_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("stall_f_instr", bus.f_instr,        32'd5);
            chk("stall_f_pc",    32'(bus.f_pc),      32'd5);
            chk("stall_f_valid", 32'(bus.f_valid),   32'd1);
            tick();
        end
        push_f(32'd5, 5); push_f(32'd6, 6); push_f(32'd7, 7);
        bus.f_ready = 1'b1;
        drain("poststall", n);
        bus.f_ready = 1'b0;
        chk("poststall_cycles", 32'(n), 32'd3);

        // Redirect to 3, then redirect to 9 while f_pc=3
        bus.redirect    = 1'b1;
        bus.redirect_pc = IMW'(3);
        tick();
        bus.redirect = 1'b0;
        chk("redir3_bubble", 32'(bus.f_valid), 32'd0);
        tick();
        chk("redir3_f_pc",    32'(bus.f_pc),    32'd3);
        chk("redir3_f_valid", 32'(bus.f_valid), 32'd1);
        bus.redirect    = 1'b1;
        bus.redirect_pc = IMW'(9);
        tick();
        bus.redirect = 1'b0;
        chk("redir9_bubble", 32'(bus.f_valid), 32'd0);
        chk("redir9_nop",    bus.f_instr,      NOP);
        push_f(32'd9, 9); push_f(32'd10, 10);
        bus.f_ready = 1'b1;
        drain("redir9", n);
        bus.f_ready = 1'b0;
        chk("redir9_cycles", 32'(n), 32'd3);

        // Load two words
        push_w(0, 32'h00000013);
        push_w(1, 32'h000006B3);
        start_load(2);
        chk("load_busy",     32'(bus.busy_load), 32'd1);
        chk("load_f_valid",  32'(bus.f_valid),   32'd0);
        chk("load_f_instr",  bus.f_instr,        NOP);
        chk("load_ld_ready", 32'(bus.ld_ready),  32'd1);
        for (int i = 0; i < 8; i++) send_byte(prog[i], 0);
        chk("load_write_ld_ready", 32'(bus.ld_ready), 32'd0);
        wait_run("load_done");
        chk("load_run_addr",    32'(bus.im_addr), 32'd0);
        chk("load_run_f_valid", 32'(bus.f_valid), 32'd0);
        push_f(32'h00000013, 0);
        push_f(32'h000006B3, 1);
        bus.f_ready = 1'b1;
        drain("load_fetch", n);
        bus.f_ready = 1'b0;

        // Throttled load with a redirect held throughout
        push_w(0, 32'h00000013);
        push_w(1, 32'h000006B3);
        bus.redirect    = 1'b1;
        bus.redirect_pc = IMW'(7);
        start_load(2);
        for (int i = 0; i < 8; i++) send_byte(prog[i], (i % 2) + 1);
        bus.redirect = 1'b0;
        wait_run("tload_done");
        chk("tload_f_valid", 32'(bus.f_valid), 32'd0);
        push_f(32'h00000013, 0);
        push_f(32'h000006B3, 1);
        bus.f_ready = 1'b1;
        drain("tload_fetch", n);
        bus.f_ready = 1'b0;

        // Zero-length load: straight back to RUN at pc 0, no writes
        start_load(0);
        chk("len0_busy", 32'(bus.busy_load), 32'd1);
        tick();
        chk("len0_run",      32'(bus.busy_load), 32'd0);
        chk("len0_f_valid0", 32'(bus.f_valid),   32'd0);
        tick();
        chk("len0_f_valid1", 32'(bus.f_valid), 32'd1);
        chk("len0_f_pc",     32'(bus.f_pc),    32'd0);
        chk("len0_f_instr",  bus.f_instr,      32'h00000013);

        // Reset after two bytes of a load
        start_load(2);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy",     32'(bus.busy_load), 32'd0);
        chk("mid_rst_ld_ready", 32'(bus.ld_ready),  32'd0);
        chk("mid_rst_im_we",    32'(bus.im_we),     32'd0);
        chk("mid_rst_f_instr",  bus.f_instr,        NOP);
        chk("mid_rst_wdata",    bus.im_wdata,       32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        chk("post_rst_f_valid", 32'(bus.f_valid), 32'd0);
        chk("post_rst_addr",    32'(bus.im_addr), 32'd0);
        push_f(32'h00000013, 0);
        bus.f_ready = 1'b1;
        drain("post_rst_fetch", n);
        bus.f_ready = 1'b0;
        tick();
        tick();

        chk("end_fetch_queue", 32'(fq.size()), 32'd0);
        chk("end_write_queue", 32'(wq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
